axi_adapter_arbiter: RTL

- Shares one AXI adapter (single-outstanding request/grant/valid interface) between NUM_REQ requesters, e.g. instruction cache, data cache and debug bus master.
- Round-robin arbitration with the grant held per transaction: one requester owns the adapter from selection until its response (valid) returns.
- Tags each transaction with the owner index and checks that tag on the response.

---
 rtl/axi_adapter_arbiter.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/axi_adapter_arbiter.sv
// axi_adapter_arbiter
// Shares one single-outstanding AXI adapter between NUM_REQ requesters.
// Arbitration is round-robin. The winner keeps the adapter from selection
// until its response returns. Each transaction carries the owner index as its
// ID, and the returned ID is checked against the current owner.
// A request type is one bit: 0 = single request, 1 = cache-line request.

module axi_adapter_arbiter #(
    parameter int NUM_REQ      = 3,
    parameter int DATA_WIDTH   = 256,
    parameter int AXI_ID_WIDTH = 10
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NUM_REQ-1:0]                    req_i,
    input  logic [NUM_REQ-1:0]                    type_i,
    input  logic [NUM_REQ-1:0][63:0]              addr_i,
    input  logic [NUM_REQ-1:0]                    we_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    wdata_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH/8-1:0]  be_i,
    input  logic [NUM_REQ-1:0][1:0]               size_i,
    output logic [NUM_REQ-1:0]                    gnt_o,
    output logic [NUM_REQ-1:0]                    valid_o,
    output logic [DATA_WIDTH-1:0]                 rdata_o,
    output logic                                  ad_req_o,
    output logic                                  ad_type_o,
    output logic [63:0]                           ad_addr_o,
    output logic                                  ad_we_o,
    output logic [DATA_WIDTH-1:0]                 ad_wdata_o,
    output logic [DATA_WIDTH/8-1:0]               ad_be_o,
    output logic [1:0]                            ad_size_o,
    output logic [AXI_ID_WIDTH-1:0]               ad_id_o,
    input  logic                                  ad_gnt_i,
    input  logic                                  ad_valid_i,
    input  logic [DATA_WIDTH-1:0]                 ad_rdata_i,
    input  logic [AXI_ID_WIDTH-1:0]               ad_id_i,
    output logic                                  err_o,
    output logic                                  busy_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] REQ      = 2'd1;
    localparam logic [1:0] WAIT_RSP = 2'd2;

    logic [1:0]         state_q;
    logic [IDX_W-1:0]   sel_q;
    logic [IDX_W-1:0]   rr_q;
    logic               err_q;

    logic [1:0]         next_state_s;
    logic [IDX_W-1:0]   next_sel_s;
    logic [IDX_W-1:0]   next_rr_s;
    logic               next_err_s;
    logic [IDX_W-1:0]   pick_s;
    logic [IDX_W-1:0]   rr_after_s;
    logic [NUM_REQ-1:0] sel_onehot_s;
    logic               grant_s;
    logic               accept_s;

    // A response ID matches only if it equals the zero-extended owner index.
    function automatic logic id_mismatch(input logic [AXI_ID_WIDTH-1:0] id,
                                         input logic [IDX_W-1:0]        owner);
        return (id != AXI_ID_WIDTH'(owner));
    endfunction

    // Round-robin pick: the lowest offset from rr_q whose request is set wins.
    // The loop runs from the highest offset down, so the last match is the lowest offset.
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        pick_s   = rr_q;
        cand     = 0;
        cand_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand     = (int'(rr_q) + i) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (req_i[cand_idx]) begin
                pick_s = cand_idx;
            end else begin
                pick_s = pick_s;
            end
        end
    end

    // Owner decode, next round-robin pointer and handshake qualifiers.
    // Handshakes are suppressed while reset is asserted.
    always_comb begin
        sel_onehot_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_q;
        rr_after_s   = IDX_W'((int'(sel_q) + 1) % NUM_REQ);
        grant_s      = !rst_i && (state_q == REQ) && ad_gnt_i;
        accept_s     = !rst_i && (((state_q == REQ) && ad_gnt_i && ad_valid_i) ||
                                  ((state_q == WAIT_RSP) && ad_valid_i));
    end

    // Next-state logic for the arbitration FSM, pointer and sticky error.
    always_comb begin
        next_state_s = state_q;
        next_sel_s   = sel_q;
        next_rr_s    = rr_q;
        next_err_s   = err_q;
        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    next_sel_s   = pick_s;
                    next_state_s = REQ;
                end else begin
                    next_state_s = IDLE;
                end
            end
            REQ: begin
                if (accept_s) begin
                    next_state_s = IDLE;
                end else if (grant_s) begin
                    next_state_s = WAIT_RSP;
                end else begin
                    next_state_s = REQ;
                end
            end
            WAIT_RSP: begin
                if (accept_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = WAIT_RSP;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
        if (accept_s) begin
            next_rr_s  = rr_after_s;
            next_err_s = err_q | id_mismatch(ad_id_i, sel_q);
        end else begin
            next_rr_s  = next_rr_s;
            next_err_s = next_err_s;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            sel_q   <= '0;
            rr_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= next_state_s;
            sel_q   <= next_sel_s;
            rr_q    <= next_rr_s;
            err_q   <= next_err_s;
        end
    end

    // Adapter request channel: driven from the owner only while in REQ, otherwise zero.
    always_comb begin
        ad_req_o   = 1'b0;
        ad_type_o  = 1'b0;
        ad_addr_o  = 64'd0;
        ad_we_o    = 1'b0;
        ad_wdata_o = '0;
        ad_be_o    = '0;
        ad_size_o  = 2'd0;
        ad_id_o    = '0;
        if (!rst_i && (state_q == REQ)) begin
            ad_req_o   = 1'b1;
            ad_type_o  = type_i[sel_q];
            ad_addr_o  = addr_i[sel_q];
            ad_we_o    = we_i[sel_q];
            ad_wdata_o = wdata_i[sel_q];
            ad_be_o    = be_i[sel_q];
            ad_size_o  = size_i[sel_q];
            ad_id_o    = AXI_ID_WIDTH'(sel_q);
        end else begin
            ad_req_o   = 1'b0;
        end
    end

    // Requester-side pulses and status. Response data passes straight through.
    always_comb begin
        gnt_o   = grant_s  ? sel_onehot_s : {NUM_REQ{1'b0}};
        valid_o = accept_s ? sel_onehot_s : {NUM_REQ{1'b0}};
        rdata_o = ad_rdata_i;
        err_o   = err_q && !rst_i;
        busy_o  = (state_q != IDLE) && !rst_i;
    end

endmodule
